// File: rtl/apb_reg_completer.sv
// APB3 completer: NUM_REGS read/write words plus a read-only write counter at index NUM_REGS,
// with WAIT_CYCLES wait states per access and all bus outputs registered.
module apb_reg_completer #(
    parameter int NUM_REGS    = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                   hclk,
    input  logic                   hresetn,
    input  logic                   psel,
    input  logic                   penable,
    input  logic                   pwrite,
    input  logic [31:0]            paddr,
    input  logic [31:0]            pwdata,
    output logic [31:0]            prdata,
    output logic                   pready,
    output logic                   pslverr,
    output logic [NUM_REGS*32-1:0] reg_out
);
    localparam int          IW       = $clog2(NUM_REGS + 1);
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [29:0] IDX_WCNT = 30'(NUM_REGS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          wr_q, wr_d;
    logic          err_q, err_d;
    logic [31:0]   regs_q [NUM_REGS];
    logic [31:0]   regs_d [NUM_REGS];
    logic [31:0]   wr_count_q, wr_count_d;
    logic [31:0]   prdata_q, prdata_d;
    logic          pready_q, pready_d;
    logic          pslverr_q, pslverr_d;

    logic [29:0]   setup_idx;
    logic          setup_err;
    logic [31:0]   rd_val;

    always_comb begin
        setup_idx = paddr[31:2];
        setup_err = (paddr[1:0] != 2'b00) || (setup_idx > IDX_WCNT) ||
                    (pwrite && (setup_idx == IDX_WCNT));

        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wr_d       = wr_q;
        err_d      = err_q;
        regs_d     = regs_q;
        wr_count_d = wr_count_q;

        case (state_q)
            S_IDLE: begin
                // penable without a preceding setup phase is not a transfer
                if (psel && !penable) begin
                    idx_d   = setup_idx[IW-1:0];
                    wr_d    = pwrite;
                    err_d   = setup_err;
                    cnt_d   = CNT_INIT;
                    state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (!psel) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (!psel) begin
                    state_d = S_IDLE;
                end else if (penable) begin
                    if (wr_q && !err_q) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (idx_q == IW'(i)) regs_d[i] = pwdata;
                        end
                        wr_count_d = wr_count_q + 32'd1;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Read data is captured on entry to RESP; registers cannot change while waiting.
        rd_val = '0;
        if (idx_d == IW'(NUM_REGS)) rd_val = wr_count_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx_d == IW'(i)) rd_val = regs_q[i];
        end

        pready_d  = (state_d == S_RESP);
        pslverr_d = pready_d && err_d;
        prdata_d  = (pready_d && !err_d && !wr_d) ? rd_val : 32'd0;
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
            regs_q     <= '{default: '0};
            wr_count_q <= '0;
            prdata_q   <= '0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wr_q       <= wr_d;
            err_q      <= err_d;
            regs_q     <= regs_d;
            wr_count_q <= wr_count_d;
            prdata_q   <= prdata_d;
            pready_q   <= pready_d;
            pslverr_q  <= pslverr_d;
        end
    end

    always_comb begin
        reg_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_out[32*i +: 32] = regs_q[i];
        end
    end

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_reg_completer.sv
// Bench for apb_reg_completer: three instances (0, 2 and 3 wait states) share one APB bus and
// are checked against a per-instance register/counter model.
module tb_apb_reg_completer;
    localparam int NR = 8;
    localparam int WS [3] = '{0, 2, 3};

    logic          hclk;
    logic          hresetn;
    logic          psel, penable, pwrite;
    logic [31:0]   paddr, pwdata;
    logic [31:0]   prdata  [3];
    logic          pready  [3];
    logic          pslverr [3];
    logic [NR*32-1:0] reg_out [3];

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [3][NR];
    logic [31:0] m_cnt  [3];

    apb_reg_completer #(.NUM_REGS(NR), .WAIT_CYCLES(0)) u_w0 (
        .hclk(hclk), .hresetn(hresetn), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata[0]), .pready(pready[0]),
        .pslverr(pslverr[0]), .reg_out(reg_out[0]));
    apb_reg_completer #(.NUM_REGS(NR), .WAIT_CYCLES(2)) u_w2 (
        .hclk(hclk), .hresetn(hresetn), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata[1]), .pready(pready[1]),
        .pslverr(pslverr[1]), .reg_out(reg_out[1]));
    apb_reg_completer #(.NUM_REGS(NR), .WAIT_CYCLES(3)) u_w3 (
        .hclk(hclk), .hresetn(hresetn), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata[2]), .pready(pready[2]),
        .pslverr(pslverr[2]), .reg_out(reg_out[2]));

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [NR*32-1:0] act, input logic [NR*32-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit m_err(input bit wr, input logic [31:0] a);
        logic [29:0] idx;
        idx = a[31:2];
        return (a[1:0] != 2'b00) || (idx > 30'd8) || (wr && (idx == 30'd8));
    endfunction

    function automatic logic [NR*32-1:0] m_vec(input int i);
        logic [NR*32-1:0] v;
        for (int j = 0; j < NR; j++) v[32*j +: 32] = m_regs[i][j];
        return v;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = '0;
            for (int j = 0; j < NR; j++) m_regs[i][j] = '0;
        end
    endtask

    // One transfer with ncyc enable cycles; an instance commits only if ncyc covers its latency.
    // Returns with psel/penable still high so the final edge completes the transfer.
    task automatic apb_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input int ncyc, output logic [31:0] rd0, output logic err0);
        bit          e;
        bit          exp_rdy;
        logic [29:0] idx;
        logic [31:0] exp_rd [3];
        e   = m_err(wr, addr);
        idx = addr[31:2];
        for (int i = 0; i < 3; i++)
            exp_rd[i] = (e || wr) ? 32'd0 : ((idx == 30'd8) ? m_cnt[i] : m_regs[i][idx[2:0]]);
        rd0  = '0;
        err0 = 1'b0;
        @(negedge hclk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = ~wdata;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge hclk);
            penable = 1'b1; pwdata = wdata;
            for (int i = 0; i < 3; i++) begin
                exp_rdy = (k == WS[i] + 1);
                chk($sformatf("w%0d pready cyc%0d", WS[i], k), 32'(pready[i]), 32'(exp_rdy));
                chk($sformatf("w%0d pslverr cyc%0d", WS[i], k), 32'(pslverr[i]), 32'(exp_rdy && e));
                chk($sformatf("w%0d prdata cyc%0d", WS[i], k), prdata[i], exp_rdy ? exp_rd[i] : 32'd0);
            end
            if (k == 1) begin
                rd0  = prdata[0];
                err0 = pslverr[0];
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (ncyc >= WS[i] + 1 && wr && !e) begin
                m_regs[i][idx[2:0]] = wdata;
                m_cnt[i] = m_cnt[i] + 32'd1;
            end
        end
    endtask

    task automatic idle_chk();
        @(negedge hclk);
        psel = 1'b0; penable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("w%0d idle pready", WS[i]), 32'(pready[i]), 32'd0);
            chk($sformatf("w%0d idle pslverr", WS[i]), 32'(pslverr[i]), 32'd0);
            chk($sformatf("w%0d idle prdata", WS[i]), prdata[i], 32'd0);
            chk_w($sformatf("w%0d reg_out", WS[i]), reg_out[i], m_vec(i));
        end
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    initial begin
        vec_t        tbl [12];
        logic [31:0] rd;
        logic        er;
        bit          wr_b;
        int          idx;
        int          ncyc;
        logic [31:0] addr;
        logic [31:0] wdata;

        tbl[0]  = '{1'b1, 32'h04, 32'hDEAD_BEEF, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 32'h04, 32'h0,         1'b0, 32'hDEAD_BEEF};
        tbl[2]  = '{1'b0, 32'h00, 32'h0,         1'b0, 32'h0};
        tbl[3]  = '{1'b1, 32'h02, 32'h1111_1111, 1'b1, 32'h0};
        tbl[4]  = '{1'b0, 32'h40, 32'h0,         1'b1, 32'h0};
        tbl[5]  = '{1'b1, 32'h20, 32'h2222_2222, 1'b1, 32'h0};
        tbl[6]  = '{1'b0, 32'h20, 32'h0,         1'b0, 32'h1};
        tbl[7]  = '{1'b0, 32'h1C, 32'h0,         1'b0, 32'h0};
        tbl[8]  = '{1'b0, 32'h24, 32'h0,         1'b1, 32'h0};
        tbl[9]  = '{1'b1, 32'h1C, 32'hA5A5_0001, 1'b0, 32'h0};
        tbl[10] = '{1'b0, 32'h1C, 32'h0,         1'b0, 32'hA5A5_0001};
        tbl[11] = '{1'b0, 32'h20, 32'h0,         1'b0, 32'h2};

        hresetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0;
        m_reset();
        repeat (3) @(negedge hclk);
        for (int i = 0; i < 3; i++) begin
            chk("reset pready", 32'(pready[i]), 32'd0);
            chk("reset pslverr", 32'(pslverr[i]), 32'd0);
            chk("reset prdata", prdata[i], 32'd0);
            chk_w("reset reg_out", reg_out[i], '0);
        end
        hresetn = 1'b1;
        idle_chk();

        for (int j = 0; j < 12; j++) begin
            apb_xfer(tbl[j].wr, tbl[j].addr, tbl[j].wdata, 4, rd, er);
            chk($sformatf("tbl%0d pslverr", j), 32'(er), 32'(tbl[j].exp_err));
            chk($sformatf("tbl%0d prdata", j), rd, tbl[j].exp_rd);
            idle_chk();
        end

        // Write counter: three more good writes back-to-back, then read it
        apb_xfer(1'b1, 32'h00, 32'h0000_0010, 4, rd, er);
        apb_xfer(1'b1, 32'h10, 32'h0000_0020, 4, rd, er);
        apb_xfer(1'b1, 32'h18, 32'h0000_0030, 4, rd, er);
        apb_xfer(1'b0, 32'h20, 32'h0, 4, rd, er);
        chk("wr_count after 5 writes", rd, 32'd5);
        idle_chk();

        @(negedge hclk);
        force u_w0.wr_count_d = 32'hFFFF_FFFF;
        force u_w2.wr_count_d = 32'hFFFF_FFFF;
        force u_w3.wr_count_d = 32'hFFFF_FFFF;
        @(negedge hclk);
        release u_w0.wr_count_d;
        release u_w2.wr_count_d;
        release u_w3.wr_count_d;
        for (int i = 0; i < 3; i++) m_cnt[i] = 32'hFFFF_FFFF;
        apb_xfer(1'b0, 32'h20, 32'h0, 4, rd, er);
        chk("wr_count preload", rd, 32'hFFFF_FFFF);
        idle_chk();
        apb_xfer(1'b1, 32'h14, 32'h0000_0077, 4, rd, er);
        idle_chk();
        apb_xfer(1'b0, 32'h20, 32'h0, 4, rd, er);
        chk("wr_count wrap", rd, 32'd0);
        idle_chk();

        // Abort: psel dropped after one enable cycle; only the zero-wait instance completes
        apb_xfer(1'b1, 32'h08, 32'h0000_1234, 1, rd, er);
        idle_chk();
        chk("w2 abort reg2", reg_out[1][95:64], 32'd0);
        chk("w3 abort reg2", reg_out[2][95:64], 32'd0);
        apb_xfer(1'b0, 32'h20, 32'h0, 4, rd, er);
        idle_chk();

        for (int n = 0; n < 60; n++) begin
            wr_b  = 1'($urandom_range(0, 1));
            idx   = $urandom_range(0, 10);
            addr  = 32'(idx) << 2;
            if ($urandom_range(0, 9) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 19) == 0) addr[31:28] = 4'($urandom_range(1, 15));
            wdata = $urandom;
            ncyc  = ($urandom_range(0, 7) == 0) ? 1 : 4;
            apb_xfer(wr_b, addr, wdata, ncyc, rd, er);
            if (ncyc != 4 || $urandom_range(0, 2) == 0) idle_chk();
        end
        idle_chk();

        // Reset while the 3-wait instance sits in RESP of a write
        apb_xfer(1'b1, 32'h0C, 32'hCAFE_F00D, 3, rd, er);
        @(negedge hclk);
        chk("w3 pready before reset", 32'(pready[2]), 32'd1);
        hresetn = 1'b0;
        #1;
        m_reset();
        for (int i = 0; i < 3; i++) begin
            chk("midreset pready", 32'(pready[i]), 32'd0);
            chk("midreset pslverr", 32'(pslverr[i]), 32'd0);
            chk("midreset prdata", prdata[i], 32'd0);
            chk_w("midreset reg_out", reg_out[i], '0);
        end
        @(negedge hclk);
        hresetn = 1'b1; psel = 1'b0; penable = 1'b0;
        idle_chk();
        apb_xfer(1'b0, 32'h0C, 32'h0, 4, rd, er);
        chk("reg3 after reset", rd, 32'd0);
        idle_chk();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
